// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the unified instruction/data memory arbiter.
// Contents : arb_state_t - arbiter FSM states
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_D_ACC  = 3'd1,
      ST_I_ACC  = 3'd2,
      ST_I_DROP = 3'd3,
      ST_D_DONE = 3'd4,
      ST_I_DONE = 3'd5
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_watchdog
// Purpose  : Counts cycles an access waits for its acknowledge and raises a
//            sticky error flag once the count reaches TIMEOUT.
// Ports    : clk, rst   - clock, synchronous active-high reset
//            clear      - restart the count (new grant)
//            run        - an access is waiting for its acknowledge
//            err        - sticky timeout flag, cleared only by rst
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic err
);

   localparam int            CW    = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;
   logic          err_q;

   // The count saturates at LIMIT; the flag sets on the edge where the
   // count reaches LIMIT, so it is visible the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         err_q <= 1'b0;
      end else begin
         if (clear) begin
            count <= '0;
         end else if (run && (count != LIMIT)) begin
            count <= count + 1'b1;
         end
         if (run && !clear && (count == LIMIT - 1'b1)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-ported memory between instruction fetch and
//            the Memory-stage load/store port of a 5-stage RV32I pipeline.
//            One access at a time; the request is held until acknowledged.
// Ports    : clk/rst                     - clock, synchronous active-high reset
//            IReqF_i/IAddrF_i/FlushF_i   - fetch request, address, PC redirect
//            InstrF_o/IReadyF_o          - fetched instruction + 1-cycle strobe
//            DReqM_i/DWeM_i/DAddrM_i/
//            DWDataM_i/DBeM_i            - load/store request
//            DRDataM_o/DReadyM_o         - load data + 1-cycle completion strobe
//            StallF_o/StallM_o           - pipeline freeze to hazard unit
//            mem_*                       - memory-side request/response
//            ErrTimeout_o                - sticky acknowledge timeout
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            IReqF_i,
   input  logic [AW-1:0]   IAddrF_i,
   output logic [DW-1:0]   InstrF_o,
   output logic            IReadyF_o,
   input  logic            FlushF_i,
   input  logic            DReqM_i,
   input  logic            DWeM_i,
   input  logic [AW-1:0]   DAddrM_i,
   input  logic [DW-1:0]   DWDataM_i,
   input  logic [DW/8-1:0] DBeM_i,
   output logic [DW-1:0]   DRDataM_o,
   output logic            DReadyM_o,
   output logic            StallF_o,
   output logic            StallM_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_be_o,
   input  logic [DW-1:0]   mem_rdata_i,
   input  logic            mem_ack_i,
   output logic            ErrTimeout_o
);

   localparam int BW = DW / 8;

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic          last_d;
   logic          grant_d;
   logic          grant_i;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [BW-1:0] be_q;
   logic [DW-1:0] instr_q;
   logic [DW-1:0] drdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      mem_req_o = 1'b0;
      DReadyM_o = 1'b0;
      IReadyF_o = 1'b0;
      case (state)
         ST_IDLE: begin
            // Data wins a tie unless it won the previous grant, so a
            // continuous stream of loads/stores cannot starve fetch.
            grant_d = DReqM_i & (~IReqF_i | ~last_d);
            grant_i = IReqF_i & ~grant_d;
            if (grant_d) begin
               state_nxt = ST_D_ACC;
            end else if (grant_i) begin
               state_nxt = ST_I_ACC;
            end
         end
         ST_D_ACC: begin
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               state_nxt = ST_D_DONE;
            end
         end
         ST_I_ACC: begin
            mem_req_o = 1'b1;
            // A redirect coinciding with the ack makes the returned word
            // stale already, so it is discarded like any dropped fetch.
            if (mem_ack_i) begin
               state_nxt = FlushF_i ? ST_IDLE : ST_I_DONE;
            end else if (FlushF_i) begin
               state_nxt = ST_I_DROP;
            end
         end
         ST_I_DROP: begin
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               state_nxt = ST_IDLE;
            end
         end
         // The DONE states take no grant, so the requester that just
         // completed has a cycle to drop or change its request.
         ST_D_DONE: begin
            DReadyM_o = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_I_DONE: begin
            IReadyF_o = ~FlushF_i;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_d   <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         instr_q  <= '0;
         drdata_q <= '0;
      end else begin
         if (grant_d) begin
            last_d  <= 1'b1;
            addr_q  <= DAddrM_i;
            we_q    <= DWeM_i;
            wdata_q <= DWDataM_i;
            be_q    <= DWeM_i ? DBeM_i : '1;
         end else if (grant_i) begin
            last_d  <= 1'b0;
            addr_q  <= IAddrF_i;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
         end
         if ((state == ST_D_ACC) && mem_ack_i) begin
            drdata_q <= mem_rdata_i;
         end
         if ((state == ST_I_ACC) && mem_ack_i && !FlushF_i) begin
            instr_q <= mem_rdata_i;
         end
      end
   end

   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;
   assign InstrF_o    = instr_q;
   assign DRDataM_o   = drdata_q;

   assign StallM_o = DReqM_i & ~DReadyM_o;
   assign StallF_o = (IReqF_i & ~IReadyF_o) | StallM_o;

   // Waiting covers every state that holds mem_req_o high.
   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .clear (grant_d | grant_i),
      .run   (mem_req_o),
      .err   (ErrTimeout_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Self-checking bench for unified_mem_arbiter. A memory device
//            model answers requests; expected responses are queued when
//            stimulus is issued and compared by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dreq_t;

   typedef struct packed {
      logic        is_load;
      logic [31:0] val;
   } dresp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          IReqF = 1'b0;
   logic [AW-1:0] IAddrF = '0;
   logic          FlushF = 1'b0;
   logic          DReqM = 1'b0;
   logic          DWeM = 1'b0;
   logic [AW-1:0] DAddrM = '0;
   logic [DW-1:0] DWDataM = '0;
   logic [3:0]    DBeM = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] InstrF, DRDataM, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          IReadyF, DReadyM, StallF, StallM, mem_req, mem_we, err;
   logic [3:0]    mem_be;

   int checks = 0;
   int errors = 0;
   int ack_fixed = 0;
   bit no_ack = 1'b0;

   logic [31:0] exp_imem[$];
   dreq_t       exp_dmem[$];
   logic [31:0] exp_instr[$];
   dresp_t      exp_dresp[$];
   int          grant_log[$];
   logic [31:0] dev_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];

   always #5 clk = ~clk;

   unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .IReqF_i(IReqF), .IAddrF_i(IAddrF), .InstrF_o(InstrF), .IReadyF_o(IReadyF),
      .FlushF_i(FlushF),
      .DReqM_i(DReqM), .DWeM_i(DWeM), .DAddrM_i(DAddrM), .DWDataM_i(DWDataM),
      .DBeM_i(DBeM), .DRDataM_o(DRDataM), .DReadyM_o(DReadyM),
      .StallF_o(StallF), .StallM_o(StallM),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
      .mem_ack_i(mem_ack), .ErrTimeout_o(err)
   );

   // Initial memory contents: an arbitrary hash of the address.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] rd_dev(input logic [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, what);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {IReadyF, DReadyM, StallF, StallM, mem_req, mem_we, err, mem_be}, 0);
      check({tag, "_rdata"}, {InstrF, DRDataM}, 0);
      check({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
   endtask

   // Memory device: acks after ack_fixed cycles (or 1..4 random), never
   // in the first request cycle; forgets a pending access on reset.
   initial begin : memdev
      dreq_t cur;
      dreq_t e;
      int    wait_cnt;
      logic  busy;
      logic  was_rst;
      busy = 1'b0;
      wait_cnt = 0;
      cur = '0;
      forever begin
         @(posedge clk);
         was_rst = rst;
         #2;
         mem_ack = 1'b0;
         if (was_rst) begin
            busy = 1'b0;
         end else if (busy) begin
            check("mem_hold", {mem_req, mem_we, mem_addr, mem_be}, {1'b1, cur.we, cur.addr, cur.be});
            if (!no_ack) begin
               wait_cnt--;
               if (wait_cnt == 0) begin
                  mem_ack = 1'b1;
                  if (cur.we) begin
                     dev_mem[cur.addr] = merge(rd_dev(cur.addr), cur.wdata, cur.be);
                     mem_rdata = $urandom;
                  end else begin
                     mem_rdata = rd_dev(cur.addr);
                  end
                  busy = 1'b0;
               end
            end
         end else if (mem_req) begin
            cur = {mem_we, mem_addr, mem_wdata, mem_be};
            if (mem_addr[12]) begin
               grant_log.push_back(0);
               if (exp_imem.size() == 0) fail_now("imem_req", "unexpected fetch request");
               else check("imem_req", {mem_we, mem_addr, mem_be}, {1'b0, exp_imem.pop_front(), 4'hF});
            end else begin
               grant_log.push_back(1);
               if (exp_dmem.size() == 0) fail_now("dmem_req", "unexpected data request");
               else begin
                  e = exp_dmem.pop_front();
                  check("dmem_req", {mem_we, mem_addr, mem_be}, {e.we, e.addr, e.be});
                  if (e.we) check("dmem_wdata", mem_wdata, e.wdata);
               end
            end
            busy = 1'b1;
            wait_cnt = (ack_fixed > 0) ? ack_fixed : int'($urandom_range(1, 4));
         end
      end
   end

   // Scoreboard monitor: stall relations every cycle, responses on strobes.
   initial begin : monitor
      dresp_t r;
      forever begin
         @(negedge clk);
         check("stallM", StallM, DReqM & ~DReadyM);
         check("stallF", StallF, (IReqF & ~IReadyF) | (DReqM & ~DReadyM));
         if (IReadyF) begin
            if (exp_instr.size() == 0) fail_now("ifetch_ready", "unexpected IReadyF_o pulse");
            else check("ifetch_data", InstrF, exp_instr.pop_front());
         end
         if (DReadyM) begin
            if (exp_dresp.size() == 0) fail_now("data_ready", "unexpected DReadyM_o pulse");
            else begin
               r = exp_dresp.pop_front();
               if (r.is_load) check("load_data", DRDataM, r.val);
            end
         end
      end
   end

   task automatic wait_iready(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (IReadyF) break;
         n++;
         if (n > 100) begin
            fail_now(tag, "IReadyF_o stayed 0 for 100 cycles, expected 1");
            break;
         end
      end
   endtask

   task automatic wait_dready(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (DReadyM) break;
         n++;
         if (n > 100) begin
            fail_now(tag, "DReadyM_o stayed 0 for 100 cycles, expected 1");
            break;
         end
      end
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (mem_req) break;
         n++;
         if (n > 20) begin
            fail_now(tag, "mem_req_o stayed 0 for 20 cycles, expected 1");
            break;
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the strobe.
   task automatic fetch_op(input logic [31:0] a);
      IReqF = 1'b1;
      IAddrF = a;
      exp_imem.push_back(a);
      exp_instr.push_back(init_word(a));
      wait_iready("fetch_wait");
      @(posedge clk); #1;
   endtask

   task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
      dreq_t  e;
      dresp_t r;
      DReqM = 1'b1; DWeM = we; DAddrM = a; DWDataM = wd; DBeM = be;
      e.we = we; e.addr = a; e.wdata = wd; e.be = we ? be : 4'hF;
      exp_dmem.push_back(e);
      r.is_load = ~we;
      r.val = rd_ref(a);
      if (we) ref_mem[a] = merge(rd_ref(a), wd, be);
      exp_dresp.push_back(r);
      wait_dready("data_wait");
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; IReqF = 1'b0; DReqM = 1'b0; FlushF = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : watchdog_guard
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int lat;
      do_reset();
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;

      // Fetch only, ack one cycle after request.
      ack_fixed = 1;
      IReqF = 1'b1; IAddrF = 32'h1000;
      exp_imem.push_back(32'h1000); exp_instr.push_back(init_word(32'h1000));
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (IReadyF) begin lat = k; break; end
      end
      check("fetch_latency", lat, 3);
      @(posedge clk); #1; IReqF = 1'b0;

      // Partial store then load back.
      ack_fixed = 0;
      d_op(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
      d_op(1'b0, 32'h100, 32'h0, 4'h0);
      DReqM = 1'b0;
      check("store_merge_ref", rd_ref(32'h100), {init_word(32'h100) >> 16, 16'hBEEF} & 32'hFFFF_FFFF);

      // Flush during I_ACC, ack four cycles after request.
      ack_fixed = 4;
      IReqF = 1'b1; IAddrF = 32'h1040; exp_imem.push_back(32'h1040);
      wait_req("flush_req");
      @(posedge clk); #1;
      FlushF = 1'b1; IAddrF = 32'h1800;
      exp_imem.push_back(32'h1800); exp_instr.push_back(init_word(32'h1800));
      @(posedge clk); #1; FlushF = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("flush_hold", {mem_req, IReadyF}, 2'b10);
         if (mem_ack) break;
      end
      @(negedge clk); check("flush_gap", {mem_req, IReadyF}, 2'b00);
      @(negedge clk); check("flush_refetch", {mem_req, mem_addr}, {1'b1, 32'h1800});
      wait_iready("flush_refetch_wait");
      @(posedge clk); #1; IReqF = 1'b0;

      // Flush coinciding with I_DONE suppresses the strobe.
      ack_fixed = 1;
      IReqF = 1'b1; IAddrF = 32'h1100; exp_imem.push_back(32'h1100);
      repeat (3) @(posedge clk);
      #1;
      FlushF = 1'b1; IAddrF = 32'h1104;
      exp_imem.push_back(32'h1104); exp_instr.push_back(init_word(32'h1104));
      @(negedge clk); check("idone_flush", IReadyF, 1'b0);
      @(posedge clk); #1; FlushF = 1'b0;
      wait_iready("idone_refetch_wait");
      @(posedge clk); #1; IReqF = 1'b0;

      // Reset in the middle of a data access.
      ack_fixed = 3;
      DReqM = 1'b1; DWeM = 1'b1; DAddrM = 32'h1F0; DWDataM = 32'h0BAD_F00D; DBeM = 4'hF;
      exp_dmem.push_back({1'b1, 32'h1F0, 32'h0BAD_F00D, 4'hF});
      wait_req("rst_mid_req");
      @(posedge clk); #1; rst = 1'b1; DReqM = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_mid", {mem_req, DReadyM, err}, 3'b000);
      end
      @(posedge clk); #1;

      // Both requesters held: D first (last_d cleared by reset), then alternate.
      ack_fixed = 0;
      grant_log.delete();
      fork
         begin
            for (int k = 0; k < 4; k++) fetch_op(32'h1200 + 32'(4 * k));
            IReqF = 1'b0;
         end
         begin
            for (int k = 0; k < 4; k++) d_op(k[0], 32'h140 + 32'(4 * k), $urandom, 4'hF);
            DReqM = 1'b0;
         end
      join
      check("alt_count", grant_log.size(), 8);
      for (int k = 0; k < 8 && k < grant_log.size(); k++)
         check("alt_order", grant_log[k], (k % 2 == 0) ? 1 : 0);

      // Randomized concurrent traffic.
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               fetch_op(32'h1000 + 32'(4 * $urandom_range(0, 255)));
               if ($urandom_range(0, 2) == 0) begin
                  IReqF = 1'b0;
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
            end
            IReqF = 1'b0;
         end
         begin
            for (int k = 0; k < 30; k++) begin
               d_op(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(1, 15)));
               if ($urandom_range(0, 2) == 0) begin
                  DReqM = 1'b0;
                  repeat ($urandom_range(1, 3)) @(posedge clk);
                  #1;
               end
            end
            DReqM = 1'b0;
         end
      join

      // Memory never acknowledges: flag after TIMEOUT waiting cycles.
      do_reset();
      no_ack = 1'b1;
      IReqF = 1'b1; IAddrF = 32'h1300; exp_imem.push_back(32'h1300);
      wait_req("timeout_req");
      for (int k = 1; k <= TIMEOUT + 4; k++) begin
         if (k > 1) @(negedge clk);
         check("timeout_flag", err, k > TIMEOUT);
      end
      @(posedge clk); #1; rst = 1'b1; IReqF = 1'b0;
      @(posedge clk); #1; rst = 1'b0; no_ack = 1'b0;
      @(negedge clk);
      check_all_zero("timeout_reset");

      repeat (3) @(posedge clk);
      check("left_imem", exp_imem.size(), 0);
      check("left_dmem", exp_dmem.size(), 0);
      check("left_instr", exp_instr.size(), 0);
      check("left_dresp", exp_dresp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
